// File: rtl/led_ram_pkg.sv
// Shared types and constants for the LED colour RAM arbiter.
// Owner/port encodings, the read-pipeline stage record and the bank decode helper.
package led_ram_pkg;

   localparam int NUM_BANKS_MAX = 16;
   localparam int BANK_AW       = 9;
   localparam int DATA_W        = 8;
   localparam int BANK_W        = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_A    = 2'd1,
      OWN_B    = 2'd2
   } owner_e;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   typedef struct packed {
      logic  vld;
      port_e port;
      logic  bank_ok;
   } rd_stage_t;

   // One-hot bank select; all zeros for banks that are not populated.
   function automatic logic [NUM_BANKS_MAX-1:0] bank_onehot(input logic [BANK_W-1:0] bank,
                                                            input int num_banks);
      logic [NUM_BANKS_MAX-1:0] oh;
      oh = '0;
      if ({28'd0, bank} < num_banks)
         oh[bank] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/led_ram_arbiter_rr_pick.sv
// Combinational grant decision: a held lock wins until its burst budget is spent
// while the other port waits, otherwise ties go to the port not served last.
module led_ram_rr_pick import led_ram_pkg::*; #(
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 3
) (
   input  logic             req_a_i,
   input  logic             req_b_i,
   input  owner_e           owner_i,
   input  port_e            last_served_i,
   input  logic [CNT_W-1:0] burst_cnt_i,
   output logic             gnt_a_o,
   output logic             gnt_b_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

   logic below_max;
   logic keep_a;
   logic keep_b;

   assign below_max = burst_cnt_i < CNT_MAX;
   assign keep_a    = (owner_i == OWN_A) && req_a_i && (below_max || !req_b_i);
   assign keep_b    = (owner_i == OWN_B) && req_b_i && (below_max || !req_a_i);

   always_comb begin
      gnt_a_o = 1'b0;
      gnt_b_o = 1'b0;
      if (keep_a) begin
         gnt_a_o = 1'b1;
      end else if (keep_b) begin
         gnt_b_o = 1'b1;
      end else if (req_a_i && req_b_i) begin
         if (last_served_i == PORT_A)
            gnt_b_o = 1'b1;
         else
            gnt_a_o = 1'b1;
      end else begin
         gnt_a_o = req_a_i;
         gnt_b_o = req_b_i;
      end
   end

endmodule

// File: rtl/led_ram_arbiter.sv
// Two-port arbiter in front of the banked LED colour RAM: serialises host and
// streaming accesses, registers the RAM command and returns read data to its owner.
module led_ram_arbiter #(
   parameter int NUM_BANKS = 16,
   parameter int BANK_AW   = 9,
   parameter int MAX_BURST = 4
) (
   input  logic               clk_sb,
   input  logic               reset,
   input  logic               req_a,
   input  logic               req_b,
   input  logic               we_a,
   input  logic               we_b,
   input  logic               lock_a,
   input  logic               lock_b,
   input  logic [BANK_AW+3:0] addr_a,
   input  logic [BANK_AW+3:0] addr_b,
   input  logic [7:0]         wdata_a,
   input  logic [7:0]         wdata_b,
   output logic               gnt_a,
   output logic               gnt_b,
   output logic               rvalid_a,
   output logic               rvalid_b,
   output logic [7:0]         rdata_a,
   output logic [7:0]         rdata_b,
   output logic [15:0]        ram_sel,
   output logic [15:0]        ram_we,
   output logic [BANK_AW-1:0] addr_out,
   output logic [7:0]         data_out,
   input  logic [7:0]         data_in
);
   import led_ram_pkg::*;

   localparam int AW    = BANK_AW + BANK_W;
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

   owner_e                   owner_q, owner_d;
   port_e                    last_q, last_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [NUM_BANKS_MAX-1:0] sel_q, sel_d;
   logic [NUM_BANKS_MAX-1:0] we_q, we_d;
   logic [BANK_AW-1:0]       addr_q, addr_d;
   logic [DATA_W-1:0]        data_q, data_d;
   rd_stage_t                p1_q, p1_d;
   rd_stage_t                p2_q;
   logic                     rvalid_a_q, rvalid_a_d;
   logic                     rvalid_b_q, rvalid_b_d;
   logic [DATA_W-1:0]        rdata_a_q, rdata_a_d;
   logic [DATA_W-1:0]        rdata_b_q, rdata_b_d;

   logic                     pick_a, pick_b;
   logic                     acc_a, acc_b, acc;
   port_e                    sel_port;
   owner_e                   sel_own;
   logic                     sel_we, sel_lock;
   logic [AW-1:0]            sel_addr;
   logic [DATA_W-1:0]        sel_data;
   logic [NUM_BANKS_MAX-1:0] sel_oh;
   logic [DATA_W-1:0]        rd_byte;

   led_ram_rr_pick #(
      .MAX_BURST (MAX_BURST),
      .CNT_W     (CNT_W)
   ) u_pick (
      .req_a_i       (req_a),
      .req_b_i       (req_b),
      .owner_i       (owner_q),
      .last_served_i (last_q),
      .burst_cnt_i   (cnt_q),
      .gnt_a_o       (pick_a),
      .gnt_b_o       (pick_b)
   );

   // Grants are suppressed while reset is asserted so nothing is accepted then.
   assign gnt_a = pick_a & ~reset;
   assign gnt_b = pick_b & ~reset;
   assign acc_a = req_a & gnt_a;
   assign acc_b = req_b & gnt_b;
   assign acc   = acc_a | acc_b;

   always_comb begin
      if (acc_b) begin
         sel_port = PORT_B;
         sel_own  = OWN_B;
         sel_we   = we_b;
         sel_lock = lock_b;
         sel_addr = addr_b;
         sel_data = wdata_b;
      end else begin
         sel_port = PORT_A;
         sel_own  = OWN_A;
         sel_we   = we_a;
         sel_lock = lock_a;
         sel_addr = addr_a;
         sel_data = wdata_a;
      end
   end

   assign sel_oh = bank_onehot(sel_addr[AW-1:BANK_AW], NUM_BANKS);

   always_comb begin
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      if (acc) begin
         last_d  = sel_port;
         owner_d = sel_lock ? sel_own : OWN_NONE;
         if (owner_q == sel_own)
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
         else
            cnt_d = CNT_W'(1);
      end else if ((owner_q == OWN_A && !req_a) || (owner_q == OWN_B && !req_b)) begin
         owner_d = OWN_NONE;
         cnt_d   = '0;
      end
   end

   // Address and data hold between accesses; select and write enable pulse.
   always_comb begin
      sel_d  = acc ? sel_oh : '0;
      we_d   = (acc && sel_we) ? sel_oh : '0;
      addr_d = acc ? sel_addr[BANK_AW-1:0] : addr_q;
      data_d = acc ? sel_data : data_q;
   end

   always_comb begin
      p1_d.vld     = acc && !sel_we;
      p1_d.port    = sel_port;
      p1_d.bank_ok = |sel_oh;
   end

   // Unpopulated banks read back as zero; RAM output is ignored for them.
   assign rd_byte = p2_q.bank_ok ? data_in : '0;

   always_comb begin
      rvalid_a_d = p2_q.vld && (p2_q.port == PORT_A);
      rvalid_b_d = p2_q.vld && (p2_q.port == PORT_B);
      rdata_a_d  = rvalid_a_d ? rd_byte : rdata_a_q;
      rdata_b_d  = rvalid_b_d ? rd_byte : rdata_b_q;
   end

   always_ff @(posedge clk_sb) begin
      if (reset) begin
         owner_q    <= OWN_NONE;
         last_q     <= PORT_B;
         cnt_q      <= '0;
         sel_q      <= '0;
         we_q       <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         p1_q       <= '0;
         p2_q       <= '0;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
         rdata_a_q  <= '0;
         rdata_b_q  <= '0;
      end else begin
         owner_q    <= owner_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         p1_q       <= p1_d;
         p2_q       <= p1_q;
         rvalid_a_q <= rvalid_a_d;
         rvalid_b_q <= rvalid_b_d;
         rdata_a_q  <= rdata_a_d;
         rdata_b_q  <= rdata_b_d;
      end
   end

   assign ram_sel  = sel_q;
   assign ram_we   = we_q;
   assign addr_out = addr_q;
   assign data_out = data_q;
   assign rvalid_a = rvalid_a_q;
   assign rvalid_b = rvalid_b_q;
   assign rdata_a  = rdata_a_q;
   assign rdata_b  = rdata_b_q;

endmodule

// File: tb/tb_led_ram_arbiter.sv
// Scoreboard bench for led_ram_arbiter: directed scenarios plus random traffic,
// predicted by a request-level model of the arbitration and a flat memory image.
module tb_led_ram_arbiter;
   localparam int NB   = 4;
   localparam int MAXB = 4;

   logic        clk_sb = 1'b0;
   logic        reset = 1'b1;
   logic        req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0, lock_a = 1'b0, lock_b = 1'b0;
   logic [12:0] addr_a = '0, addr_b = '0;
   logic [7:0]  wdata_a = '0, wdata_b = '0;
   logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
   logic [7:0]  rdata_a, rdata_b, data_out, data_in;
   logic [15:0] ram_sel, ram_we;
   logic [8:0]  addr_out;

   always #5 clk_sb = ~clk_sb;

   led_ram_arbiter #(.NUM_BANKS(NB), .BANK_AW(9), .MAX_BURST(MAXB)) dut (
      .clk_sb(clk_sb), .reset(reset),
      .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
      .lock_a(lock_a), .lock_b(lock_b), .addr_a(addr_a), .addr_b(addr_b),
      .wdata_a(wdata_a), .wdata_b(wdata_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
      .rvalid_a(rvalid_a), .rvalid_b(rvalid_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
      .ram_sel(ram_sel), .ram_we(ram_we), .addr_out(addr_out), .data_out(data_out),
      .data_in(data_in)
   );

   // Banked RAM array driven by the DUT.
   logic [7:0] ram [16][512];
   always @(posedge clk_sb)
      for (int b = 0; b < 16; b++)
         if (ram_sel[b]) begin
            if (ram_we[b]) ram[b][addr_out] <= data_out;
            else           data_in <= ram[b][addr_out];
         end

   typedef struct { bit v; bit we; bit lock; logic [12:0] addr; logic [7:0] data; } req_t;
   typedef struct { int cyc; logic [15:0] sel; logic [15:0] we; logic [8:0] addr; logic [7:0] data; } cmd_t;
   typedef struct { int cyc; logic [7:0] data; } rd_t;

   logic [7:0] ref_mem [16][512];
   req_t scr_a[$], scr_b[$];
   req_t cur_a, cur_b;
   cmd_t cmd_q[$];
   rd_t  rd_qa[$], rd_qb[$];
   int   holder, run, prev;   // 0 none / 1 A / 2 B
   int   cyc = 0, checks = 0, errors = 0, rst_gen = 0;
   bit   mon_en = 1'b0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
      end
   endtask

   function automatic req_t mk(bit we, bit lock, logic [12:0] addr, logic [7:0] d);
      req_t r;
      r.v = 1'b1; r.we = we; r.lock = lock; r.addr = addr; r.data = d;
      return r;
   endfunction

   function automatic req_t idle();
      req_t r;
      r.v = 1'b0; r.we = 1'b0; r.lock = 1'b0; r.addr = '0; r.data = '0;
      return r;
   endfunction

   function automatic req_t rnd_req();
      req_t r;
      r.v    = ($urandom_range(0, 9) < 7);
      r.we   = 1'($urandom_range(0, 1));
      r.lock = ($urandom_range(0, 9) < 4);
      r.addr = {4'($urandom_range(0, 5)), 9'($urandom_range(0, 15))};
      r.data = 8'($urandom);
      return r;
   endfunction

   function automatic int pick(bit ra, bit rb);
      if (holder == 1 && ra && (run < MAXB || !rb)) return 1;
      if (holder == 2 && rb && (run < MAXB || !ra)) return 2;
      if (ra && rb) return (prev == 1) ? 2 : 1;
      if (ra) return 1;
      if (rb) return 2;
      return 0;
   endfunction

   task automatic model_accept(int w);
      req_t r;
      cmd_t c;
      rd_t  d;
      int   bk;
      bit   ok;
      if (w == 0) begin
         if ((holder == 1 && !cur_a.v) || (holder == 2 && !cur_b.v)) begin
            holder = 0; run = 0;
         end
         return;
      end
      r      = (w == 1) ? cur_a : cur_b;
      run    = (holder == w) ? ((run < MAXB) ? run + 1 : run) : 1;
      holder = r.lock ? w : 0;
      prev   = w;
      bk     = int'(r.addr[12:9]);
      ok     = bk < NB;
      c.cyc  = cyc;
      c.sel  = ok ? (16'd1 << bk) : 16'd0;
      c.we   = (ok && r.we) ? (16'd1 << bk) : 16'd0;
      c.addr = r.addr[8:0];
      c.data = r.data;
      cmd_q.push_back(c);
      if (r.we) begin
         if (ok) ref_mem[bk][r.addr[8:0]] = r.data;
      end else begin
         d.cyc  = cyc + 2;
         d.data = ok ? ref_mem[bk][r.addr[8:0]] : 8'h00;
         if (w == 1) rd_qa.push_back(d); else rd_qb.push_back(d);
      end
      if (w == 1) cur_a.v = 1'b0; else cur_b.v = 1'b0;
   endtask

   task automatic step();
      int w;
      @(negedge clk_sb);
      reset = 1'b0;
      if (!cur_a.v) cur_a = (scr_a.size() > 0) ? scr_a.pop_front() : idle();
      if (!cur_b.v) cur_b = (scr_b.size() > 0) ? scr_b.pop_front() : idle();
      req_a = cur_a.v; we_a = cur_a.we; lock_a = cur_a.lock; addr_a = cur_a.addr; wdata_a = cur_a.data;
      req_b = cur_b.v; we_b = cur_b.we; lock_b = cur_b.lock; addr_b = cur_b.addr; wdata_b = cur_b.data;
      #1;
      w = pick(cur_a.v, cur_b.v);
      chk("gnt_a", gnt_a, 32'(w == 1));
      chk("gnt_b", gnt_b, 32'(w == 2));
      @(posedge clk_sb);
      cyc++;
      model_accept(w);
   endtask

   task automatic do_reset(int n);
      scr_a.delete(); scr_b.delete();
      cur_a = idle(); cur_b = idle();
      repeat (n) begin
         @(negedge clk_sb);
         reset = 1'b1; req_a = 1'b1; req_b = 1'b1; lock_a = 1'b1; lock_b = 1'b1;
         #1;
         chk("gnt_a_in_reset", gnt_a, 0);
         chk("gnt_b_in_reset", gnt_b, 0);
         @(posedge clk_sb);
         cyc++;
         holder = 0; run = 0; prev = 2;
         cmd_q.delete(); rd_qa.delete(); rd_qb.delete();
         rst_gen++;
      end
   endtask

   task automatic run_steps(int n);
      repeat (n) step();
   endtask

   // Monitor: every cycle the registered outputs must match the scoreboard.
   int         seen_gen = 0;
   cmd_t       mc;
   rd_t        mr;
   logic [8:0] m_addr = '0;
   logic [7:0] m_data = '0, m_rda = '0, m_rdb = '0;
   logic [15:0] m_sel, m_we;
   bit         m_va, m_vb;
   always @(negedge clk_sb) begin
      if (rst_gen != seen_gen) begin
         seen_gen = rst_gen;
         m_addr = '0; m_data = '0; m_rda = '0; m_rdb = '0;
      end
      if (mon_en) begin
         m_sel = '0; m_we = '0;
         if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
            mc = cmd_q.pop_front();
            m_sel = mc.sel; m_we = mc.we; m_addr = mc.addr; m_data = mc.data;
         end
         chk("ram_sel", ram_sel, m_sel);
         chk("ram_we", ram_we, m_we);
         chk("addr_out", addr_out, m_addr);
         chk("data_out", data_out, m_data);
         m_va = 1'b0;
         if (rd_qa.size() > 0 && rd_qa[0].cyc == cyc) begin
            mr = rd_qa.pop_front(); m_va = 1'b1; m_rda = mr.data;
         end
         chk("rvalid_a", rvalid_a, m_va);
         chk("rdata_a", rdata_a, m_rda);
         m_vb = 1'b0;
         if (rd_qb.size() > 0 && rd_qb[0].cyc == cyc) begin
            mr = rd_qb.pop_front(); m_vb = 1'b1; m_rdb = mr.data;
         end
         chk("rvalid_b", rvalid_b, m_vb);
         chk("rdata_b", rdata_b, m_rdb);
      end
   end

   initial begin
      for (int b = 0; b < 16; b++)
         for (int a = 0; a < 512; a++) begin
            ram[b][a]     = 8'(b * 31 + a * 7 + 3);
            ref_mem[b][a] = 8'(b * 31 + a * 7 + 3);
         end
      holder = 0; run = 0; prev = 2;
      cur_a = idle(); cur_b = idle();
      do_reset(2);
      mon_en = 1'b1;

      // Single write then read-back through port A.
      scr_a.push_back(mk(1, 0, 13'h0207, 8'h5A));
      scr_a.push_back(mk(0, 0, 13'h0207, 8'h00));
      run_steps(6);

      // Tie after reset: A first, then strict alternation.
      do_reset(1);
      for (int i = 0; i < 3; i++) begin
         scr_a.push_back(mk(0, 0, 13'(16 + i), 8'h00));
         scr_b.push_back(mk(0, 0, 13'(13'h0200 + i), 8'h00));
      end
      run_steps(9);

      // Locked 3-byte burst on B while A keeps requesting.
      do_reset(1);
      scr_a.push_back(idle());
      scr_a.push_back(mk(0, 0, 13'h0300, 8'h00));
      scr_a.push_back(mk(0, 0, 13'h0301, 8'h00));
      scr_b.push_back(mk(0, 1, 13'h0000, 8'h00));
      scr_b.push_back(mk(0, 1, 13'h0001, 8'h00));
      scr_b.push_back(mk(0, 0, 13'h0002, 8'h00));
      run_steps(9);

      // Forced handover after MAX_BURST locked accepts with B waiting.
      do_reset(1);
      for (int i = 0; i < 6; i++) scr_a.push_back(mk(1, 1, 13'(13'h0440 + i), 8'(8'hC0 + i)));
      scr_b.push_back(mk(0, 0, 13'h0441, 8'h00));
      run_steps(12);

      // Unpopulated bank 5: write dropped, read returns zero, bank 1 untouched.
      scr_a.push_back(mk(1, 0, 13'h0A05, 8'h77));
      scr_a.push_back(mk(0, 0, 13'h0A05, 8'h00));
      scr_a.push_back(mk(0, 0, 13'h0205, 8'h00));
      run_steps(7);

      // Reset one cycle after a read accept discards the pending response.
      do_reset(1);
      scr_a.push_back(mk(0, 0, 13'h0207, 8'h00));
      run_steps(1);
      do_reset(1);
      run_steps(5);

      // Random traffic with occasional resets.
      do_reset(1);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) do_reset(1 + $urandom_range(0, 1));
         if (scr_a.size() == 0) scr_a.push_back(rnd_req());
         if (scr_b.size() == 0) scr_b.push_back(rnd_req());
         step();
      end
      scr_a.delete(); scr_b.delete();
      run_steps(8);
      chk("rd_qa_drained", rd_qa.size(), 0);
      chk("rd_qb_drained", rd_qb.size(), 0);
      chk("cmd_q_drained", cmd_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_ram_arbiter.md
# led_ram_arbiter

Two-port arbiter for the shared LED colour RAM: 16 banks of 512×8, selected by one-hot `ram_sel`/`ram_we`.
- Port A is the host instruction path (single reads/writes, fills).
- Port B is the LED streaming path. It issues locked 3-byte bursts, one GRB pixel each.
- The block replaces direct RAM driving by the translator. It sits between both requesters and the RAM array, serialises their accesses, and routes read data back to the owner.

## Interface
Parameters:
- `NUM_BANKS`, 16: banks populated. Legal range 1..16.
- `BANK_AW`, 9: address bits per bank.
- `MAX_BURST`, 4: maximum consecutive locked accepts before a forced handover, if the other port is waiting.

Ports (clock and reset first):
- `clk_sb`  in  1  system clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_a`, `req_b`  in  1  access request, held until accepted.
- `we_a`, `we_b`  in  1  1 = write, 0 = read.
- `lock_a`, `lock_b`  in  1  keep ownership after this accept (burst).
- `addr_a`, `addr_b`  in  13  [12:9] bank, [8:0] byte address.
- `wdata_a`, `wdata_b`  in  8  write data.
- `gnt_a`, `gnt_b`  out  1  combinational. Accept occurs on `req && gnt` at the clock edge.
- `rvalid_a`, `rvalid_b`  out  1  one-cycle read-data strobe.
- `rdata_a`, `rdata_b`  out  8  read data, valid while `rvalid_x` is high and held afterwards.
- `ram_sel`  out  16  one-hot bank select, registered.
- `ram_we`  out  16  one-hot bank write enable, registered.
- `addr_out`  out  9  RAM address, registered.
- `data_out`  out  8  RAM write data, registered.
- `data_in`  in  8  RAM read data. Valid the cycle after the RAM samples `ram_sel`.

## Operation
State registers:
- `owner`: NONE, A or B.
- `last_served`: A or B.
- `burst_cnt`: 0..MAX_BURST.
- Read pipeline: two stages of {valid, port, bank_ok}.

Per-cycle grant decision, at most one grant per cycle:
1. If `owner` = X, `lock_x` was set on X's previous accept, `req_x` = 1, and either `burst_cnt` < MAX_BURST or the other `req` = 0: grant X.
2. Otherwise, if both ports request: grant the port ≠ `last_served`.
3. Otherwise, grant the sole requester, or none.

On accept by X:
- `last_served` ← X.
- `owner` ← X if `lock_x`, else NONE.
- `burst_cnt` ← `burst_cnt` + 1 if continuing the same lock, else 1.

RAM command (next cycle, registered):
- `ram_sel` = 1 << bank.
- `ram_we` = `we` ? (1 << bank) : 0.
- `addr_out` and `data_out` from the accepted request.

Idle cycles, with no accept:
- `ram_sel` = 0 and `ram_we` = 0.
- `addr_out` and `data_out` hold their last values.

Bank out of range (bank ≥ NUM_BANKS):
- `ram_sel` = 0 and `ram_we` = 0.
- A write is dropped.
- A read still returns `rvalid_x` with `rdata_x` = 8'h00.

A deasserted `req_x` while X owns the lock releases ownership that cycle: `owner` ← NONE and `burst_cnt` ← 0.

## Timing
- Accept at edge E0. RAM command is visible E0→E1 and sampled by the RAM at E1. `data_in` is captured at E2.
- `rvalid_x` is high E2→E3, i.e. read latency 2 cycles from accept.
- Back-to-back accepts every cycle are supported. Reads pipeline fully, so consecutive reads give consecutive `rvalid` strobes.
- Writes produce no response. `ram_we` is high exactly one cycle per accepted write.
- Reset (synchronous, active-high) clears all state, regardless of what is in flight:
  - `gnt_*` = 0 during reset.
  - `rvalid_*` = 0 and `rdata_*` = 0.
  - `ram_sel` = 0, `ram_we` = 0, `addr_out` = 0, `data_out` = 0.
  - `owner` = NONE, `last_served` = B (port A wins the first tie), `burst_cnt` = 0.
  - Pending read-pipeline entries are discarded, so no `rvalid` appears after reset.
- Simultaneous first requests after reset: A granted first, then B.
- Forced handover: with B waiting, A's (MAX_BURST+1)-th locked request is not granted. B is granted that cycle.

## Structure
- Shared package `led_ram_pkg`:
  - `NUM_BANKS_MAX` = 16, `BANK_AW` = 9, `DATA_W` = 8.
  - Owner enum {OWN_NONE, OWN_A, OWN_B}.
  - Function `bank_onehot(bank)` returning 16 bits, zero when bank ≥ NUM_BANKS.
- One sub-module, `led_ram_rr_pick`: purely combinational grant decision from the req/lock/owner/last_served/burst_cnt inputs, producing `gnt_a`/`gnt_b`.

## Test plan
- Single write then read: A writes 0x5A to addr 13'h0207 (bank 1, addr 7). `ram_we` = 16'h0002 for exactly one cycle. A reads the same address: `rvalid_a` 2 cycles after accept, `rdata_a` = 0x5A.
- Tie after reset: A and B request in the same cycle. A is granted first, B the next cycle. Then alternate A, B, A while both stay requesting.
- Locked burst: B reads 3 bytes at addr 0,1,2 with `lock_b` = 1 on the first two, while A requests continuously. Grants go B, B, B, then A. `rvalid_b` appears on 3 consecutive cycles with the correct bytes.
- Forced handover (MAX_BURST = 4): A holds `lock_a` for 6 requests while B waits. Grants go A×4, then B, then the remaining A requests.
- Out-of-range bank (NUM_BANKS = 4): write to bank 5 leaves `ram_sel` = 0 and `ram_we` = 0, and no RAM change. A read of bank 5 gives `rvalid` with `rdata` = 0x00.
- Reset mid-read: assert `reset` one cycle after a read accept. No `rvalid` follows, and all outputs are 0 the cycle after reset is sampled.
